// File: rtl/collision_checker.sv
// ---------------------------------------------------------------------------
// collision_checker
//
// Purpose:
//   Scans the three danger slots published by the object controller against
//   the dino's bounding box, one slot per game_clk cycle. Any overlap is
//   folded into the sticky isColision flag that ends the game. A full scan
//   takes five cycles: snapshot (IDLE), three checks, and a report.
//
// Ports:
//   game_clk        in   1   game tick clock
//   rst             in   1   asynchronous, active-high reset
//   game_state      in   2   0 INIT, 1 START, 2 END, 3 RESET
//   dino_pos        in  10   dino exclusive bottom row (y grows downward)
//   dino_behavior   in   1   0 sit, 1 stand
//   danger_posN     in  10   exclusive right column of slot N (N = 1..3)
//   danger_typeN    in   3   0 LOW_BIRD, 1 HIGH_BIRD, 2 SMALL, 3 MANY,
//                            4 BIG, 5..7 nothing
//   danger_enN      in   1   slot N valid
//   isColision      out  1   sticky collision flag
//   hit_slot        out  2   0 none, otherwise first slot that hit
//   scan_done       out  1   one-cycle pulse after each completed scan
// ---------------------------------------------------------------------------
module collision_checker #(
    parameter int DINO_X         = 40,
    parameter int DINO_W         = 44,
    parameter int DINO_STAND_H   = 47,
    parameter int DINO_SIT_H     = 30,
    parameter int GROUND_Y       = 400,
    parameter int LOW_BIRD_LIFT  = 32,
    parameter int HIGH_BIRD_LIFT = 60
) (
    input  logic       game_clk,
    input  logic       rst,
    input  logic [1:0] game_state,
    input  logic [9:0] dino_pos,
    input  logic       dino_behavior,
    input  logic [9:0] danger_pos1,
    input  logic [2:0] danger_type1,
    input  logic       danger_en1,
    input  logic [9:0] danger_pos2,
    input  logic [2:0] danger_type2,
    input  logic       danger_en2,
    input  logic [9:0] danger_pos3,
    input  logic [2:0] danger_type3,
    input  logic       danger_en3,
    output logic       isColision,
    output logic [1:0] hit_slot,
    output logic       scan_done
);

    localparam logic [1:0] GS_INIT  = 2'd0;
    localparam logic [1:0] GS_START = 2'd1;
    localparam logic [1:0] GS_RESET = 2'd3;

    localparam logic [2:0] T_LOW_BIRD  = 3'd0;
    localparam logic [2:0] T_HIGH_BIRD = 3'd1;
    localparam logic [2:0] T_SMALL     = 3'd2;
    localparam logic [2:0] T_MANY      = 3'd3;
    localparam logic [2:0] T_BIG       = 3'd4;

    // All geometry is done on 11 bits so 10-bit positions never wrap.
    localparam logic [10:0] DX_LEFT  = 11'(DINO_X);
    localparam logic [10:0] DX_RIGHT = 11'(DINO_X + DINO_W);
    localparam logic [10:0] STAND_H  = 11'(DINO_STAND_H);
    localparam logic [10:0] SIT_H    = 11'(DINO_SIT_H);
    localparam logic [10:0] GND_BOT  = 11'(GROUND_Y);
    localparam logic [10:0] LOW_BOT  = 11'(GROUND_Y - LOW_BIRD_LIFT);
    localparam logic [10:0] HIGH_BOT = 11'(GROUND_Y - HIGH_BIRD_LIFT);

    localparam logic [10:0] BIRD_W  = 11'd47;
    localparam logic [10:0] BIRD_H  = 11'd42;
    localparam logic [10:0] SMALL_W = 11'd19;
    localparam logic [10:0] SMALL_H = 11'd36;
    localparam logic [10:0] MANY_W  = 11'd77;
    localparam logic [10:0] MANY_H  = 11'd49;
    localparam logic [10:0] BIG_W   = 11'd27;
    localparam logic [10:0] BIG_H   = 11'd50;

    typedef enum logic [2:0] {
        IDLE,
        CHK1,
        CHK2,
        CHK3,
        REPORT
    } scan_state_t;

    scan_state_t state;
    scan_state_t next_state;

    logic       clear_req;
    logic       start_req;
    logic       do_snap;
    logic       do_check;
    logic       do_report;
    logic [1:0] chk_slot;

    logic [9:0] snap_dino_pos;
    logic       snap_behavior;
    logic [9:0] snap_pos  [3];
    logic [2:0] snap_type [3];
    logic       snap_en   [3];

    logic       hit_acc;
    logic [1:0] hit_acc_slot;

    logic [9:0] sel_pos;
    logic [2:0] sel_type;
    logic       sel_en;
    logic       sel_hit;

    // Axis-aligned overlap of one danger object against the dino box.
    // Types outside 0..4 or disabled slots never hit.
    function automatic logic slot_hit(
        input logic [9:0] pos,
        input logic [2:0] typ,
        input logic       en,
        input logic [9:0] dpos,
        input logic       beh
    );
        logic [10:0] w;
        logic [10:0] h;
        logic [10:0] obot;
        logic [10:0] p;
        logic [10:0] dp;
        logic [10:0] left;
        logic [10:0] otop;
        logic [10:0] dh;
        logic [10:0] dtop;
        logic        valid;
        logic        x_ov;
        logic        y_ov;
        begin
            w     = '0;
            h     = '0;
            obot  = GND_BOT;
            valid = 1'b1;
            case (typ)
                T_LOW_BIRD:  begin w = BIRD_W;  h = BIRD_H;  obot = LOW_BOT;  end
                T_HIGH_BIRD: begin w = BIRD_W;  h = BIRD_H;  obot = HIGH_BOT; end
                T_SMALL:     begin w = SMALL_W; h = SMALL_H; end
                T_MANY:      begin w = MANY_W;  h = MANY_H;  end
                T_BIG:       begin w = BIG_W;   h = BIG_H;   end
                default:     valid = 1'b0;
            endcase
            p    = {1'b0, pos};
            dp   = {1'b0, dpos};
            left = (p < w) ? 11'd0 : (p - w);
            otop = (obot < h) ? 11'd0 : (obot - h);
            dh   = beh ? STAND_H : SIT_H;
            dtop = (dp < dh) ? 11'd0 : (dp - dh);
            x_ov = (DX_LEFT < p) && (left < DX_RIGHT);
            y_ov = (dtop < obot) && (otop < dp);
            return en && valid && x_ov && y_ov;
        end
    endfunction

    assign clear_req = (game_state == GS_RESET) || (game_state == GS_INIT);
    assign start_req = (game_state == GS_START);

    // State register.
    always_ff @(posedge game_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control strobes. A clear request overrides everything,
    // and leaving START mid-scan abandons the scan without touching outputs.
    always_comb begin
        next_state = state;
        do_snap    = 1'b0;
        do_check   = 1'b0;
        do_report  = 1'b0;
        chk_slot   = 2'd0;
        if (clear_req) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) begin
                        do_snap    = 1'b1;
                        next_state = CHK1;
                    end
                end
                CHK1: begin
                    if (start_req) begin
                        do_check   = 1'b1;
                        chk_slot   = 2'd1;
                        next_state = CHK2;
                    end else begin
                        next_state = IDLE;
                    end
                end
                CHK2: begin
                    if (start_req) begin
                        do_check   = 1'b1;
                        chk_slot   = 2'd2;
                        next_state = CHK3;
                    end else begin
                        next_state = IDLE;
                    end
                end
                CHK3: begin
                    if (start_req) begin
                        do_check   = 1'b1;
                        chk_slot   = 2'd3;
                        next_state = REPORT;
                    end else begin
                        next_state = IDLE;
                    end
                end
                REPORT: begin
                    do_report  = start_req;
                    next_state = IDLE;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Slot selection for the check currently in progress.
    always_comb begin
        sel_pos  = snap_pos[0];
        sel_type = snap_type[0];
        sel_en   = snap_en[0];
        case (chk_slot)
            2'd2: begin
                sel_pos  = snap_pos[1];
                sel_type = snap_type[1];
                sel_en   = snap_en[1];
            end
            2'd3: begin
                sel_pos  = snap_pos[2];
                sel_type = snap_type[2];
                sel_en   = snap_en[2];
            end
            default: begin
                sel_pos  = snap_pos[0];
                sel_type = snap_type[0];
                sel_en   = snap_en[0];
            end
        endcase
    end

    assign sel_hit = slot_hit(sel_pos, sel_type, sel_en, snap_dino_pos, snap_behavior);

    // Snapshot registers and the per-scan hit accumulator.
    always_ff @(posedge game_clk or posedge rst) begin
        if (rst) begin
            snap_dino_pos <= '0;
            snap_behavior <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                snap_pos[i]  <= '0;
                snap_type[i] <= '0;
                snap_en[i]   <= 1'b0;
            end
            hit_acc      <= 1'b0;
            hit_acc_slot <= 2'd0;
        end else if (do_snap) begin
            snap_dino_pos <= dino_pos;
            snap_behavior <= dino_behavior;
            snap_pos[0]   <= danger_pos1;
            snap_type[0]  <= danger_type1;
            snap_en[0]    <= danger_en1;
            snap_pos[1]   <= danger_pos2;
            snap_type[1]  <= danger_type2;
            snap_en[1]    <= danger_en2;
            snap_pos[2]   <= danger_pos3;
            snap_type[2]  <= danger_type3;
            snap_en[2]    <= danger_en3;
            hit_acc       <= 1'b0;
            hit_acc_slot  <= 2'd0;
        end else if (do_check && sel_hit) begin
            hit_acc <= 1'b1;
            if (!hit_acc) begin
                hit_acc_slot <= chk_slot;
            end
        end
    end

    // Published outputs. hit_slot only latches the first slot that ever hit
    // since the last clear, so later scans cannot overwrite it.
    always_ff @(posedge game_clk or posedge rst) begin
        if (rst) begin
            isColision <= 1'b0;
            hit_slot   <= 2'd0;
            scan_done  <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (clear_req) begin
                isColision <= 1'b0;
                hit_slot   <= 2'd0;
            end else if (do_report) begin
                isColision <= isColision | hit_acc;
                if ((hit_slot == 2'd0) && hit_acc) begin
                    hit_slot <= hit_acc_slot;
                end
                scan_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_collision_checker.sv
// ---------------------------------------------------------------------------
// tb_collision_checker
//
// Purpose:
//   Directed self-checking bench for collision_checker. Each scan's expected
//   isColision/hit_slot pair is queued when the scan is launched and popped
//   when scan_done is seen.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_collision_checker;

    localparam logic [1:0] GS_INIT  = 2'd0;
    localparam logic [1:0] GS_START = 2'd1;
    localparam logic [1:0] GS_END   = 2'd2;
    localparam logic [1:0] GS_RESET = 2'd3;

    localparam logic [2:0] T_LOW   = 3'd0;
    localparam logic [2:0] T_HIGH  = 3'd1;
    localparam logic [2:0] T_SMALL = 3'd2;
    localparam logic [2:0] T_BIG   = 3'd4;
    localparam logic [2:0] T_NONE  = 3'd5;

    logic       game_clk = 1'b0;
    logic       rst;
    logic [1:0] game_state;
    logic [9:0] dino_pos;
    logic       dino_behavior;
    logic [9:0] danger_pos1, danger_pos2, danger_pos3;
    logic [2:0] danger_type1, danger_type2, danger_type3;
    logic       danger_en1, danger_en2, danger_en3;
    logic       isColision;
    logic [1:0] hit_slot;
    logic       scan_done;

    typedef struct {
        string      tag;
        logic       coll;
        logic [1:0] slot;
    } exp_t;

    exp_t sb[$];
    int   assert_count = 0;
    int   fail_count   = 0;

    collision_checker dut (
        .game_clk      (game_clk),
        .rst           (rst),
        .game_state    (game_state),
        .dino_pos      (dino_pos),
        .dino_behavior (dino_behavior),
        .danger_pos1   (danger_pos1),
        .danger_type1  (danger_type1),
        .danger_en1    (danger_en1),
        .danger_pos2   (danger_pos2),
        .danger_type2  (danger_type2),
        .danger_en2    (danger_en2),
        .danger_pos3   (danger_pos3),
        .danger_type3  (danger_type3),
        .danger_en3    (danger_en3),
        .isColision    (isColision),
        .hit_slot      (hit_slot),
        .scan_done     (scan_done)
    );

    always #5 game_clk = ~game_clk;

    task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic setSlot(input int n, input logic en, input logic [2:0] typ, input logic [9:0] pos);
        case (n)
            1: begin danger_en1 = en; danger_type1 = typ; danger_pos1 = pos; end
            2: begin danger_en2 = en; danger_type2 = typ; danger_pos2 = pos; end
            default: begin danger_en3 = en; danger_type3 = typ; danger_pos3 = pos; end
        endcase
    endtask

    task automatic setDino(input logic [9:0] pos, input logic beh);
        dino_pos      = pos;
        dino_behavior = beh;
    endtask

    task automatic clearOutputs();
        @(negedge game_clk);
        game_state = GS_INIT;
        @(negedge game_clk);
        game_state = GS_END;
    endtask

    // Launches one scan and queues what it must report.
    task automatic applyStimulus(input string tag, input logic coll, input logic [1:0] slot);
        exp_t e;
        @(negedge game_clk);
        game_state = GS_START;
        e.tag  = tag;
        e.coll = coll;
        e.slot = slot;
        sb.push_back(e);
    endtask

    // Waits (bounded) for scan_done, checks its latency and the queued result,
    // then parks the game in END and confirms the pulse lasted one cycle.
    task automatic checkOutput(input int exp_lat);
        exp_t e;
        int   lat;
        bit   seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            @(negedge game_clk);
            lat++;
            if (scan_done === 1'b1) seen = 1'b1;
        end
        e = sb.pop_front();
        checkValue({e.tag, "/latency"}, 16'(lat), 16'(exp_lat));
        checkValue({e.tag, "/isColision"}, 16'(isColision), 16'(e.coll));
        checkValue({e.tag, "/hit_slot"}, 16'(hit_slot), 16'(e.slot));
        game_state = GS_END;
        @(negedge game_clk);
        checkValue({e.tag, "/pulse_width"}, 16'(scan_done), 16'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        rst        = 1'b1;
        game_state = GS_END;
        setDino(10'd400, 1'b1);
        setSlot(1, 1'b0, T_NONE, 10'd0);
        setSlot(2, 1'b0, T_NONE, 10'd0);
        setSlot(3, 1'b0, T_NONE, 10'd0);
        repeat (3) @(negedge game_clk);
        checkValue("reset/isColision", 16'(isColision), 16'd0);
        checkValue("reset/hit_slot", 16'(hit_slot), 16'd0);
        checkValue("reset/scan_done", 16'(scan_done), 16'd0);
        rst = 1'b0;

        // Big cactus overlapping a standing dino on the ground.
        clearOutputs();
        setSlot(1, 1'b1, T_BIG, 10'd60);
        applyStimulus("big_hit", 1'b1, 2'd1);
        checkOutput(5);

        // END holds the result.
        repeat (3) @(negedge game_clk);
        checkValue("end_hold/isColision", 16'(isColision), 16'd1);
        checkValue("end_hold/hit_slot", 16'(hit_slot), 16'd1);

        // One edge of RESET clears both outputs.
        @(negedge game_clk);
        game_state = GS_RESET;
        @(negedge game_clk);
        game_state = GS_END;
        checkValue("reset_state/isColision", 16'(isColision), 16'd0);
        checkValue("reset_state/hit_slot", 16'(hit_slot), 16'd0);

        // Cactus spans [13,40): misses the dino by one column, three scans.
        setSlot(1, 1'b1, T_BIG, 10'd40);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("miss_by_one", 1'b0, 2'd0);
            checkOutput(5);
        end

        // Low bird in slot 2 against posture.
        setSlot(1, 1'b0, T_NONE, 10'd0);
        setSlot(2, 1'b1, T_LOW, 10'd80);
        setDino(10'd400, 1'b1);
        applyStimulus("low_bird_stand", 1'b1, 2'd2);
        checkOutput(5);
        clearOutputs();
        setDino(10'd400, 1'b0);
        applyStimulus("low_bird_sit", 1'b0, 2'd0);
        checkOutput(5);
        setSlot(2, 1'b1, T_HIGH, 10'd80);
        setDino(10'd400, 1'b1);
        applyStimulus("high_bird_ground", 1'b0, 2'd0);
        checkOutput(5);
        setDino(10'd340, 1'b1);
        applyStimulus("high_bird_jump", 1'b1, 2'd2);
        checkOutput(5);

        // A later hit in another slot keeps the first recorded slot.
        setSlot(2, 1'b0, T_NONE, 10'd0);
        setSlot(3, 1'b1, T_BIG, 10'd60);
        setDino(10'd400, 1'b1);
        applyStimulus("sticky_slot", 1'b1, 2'd2);
        checkOutput(5);

        // Disabled slot and non-object types never hit.
        clearOutputs();
        setSlot(1, 1'b0, T_BIG, 10'd60);
        setSlot(2, 1'b1, T_NONE, 10'd60);
        setSlot(3, 1'b1, 3'd7, 10'd60);
        applyStimulus("invalid_5_7", 1'b0, 2'd0);
        checkOutput(5);
        setSlot(2, 1'b1, 3'd6, 10'd60);
        applyStimulus("invalid_6", 1'b0, 2'd0);
        checkOutput(5);

        // Slots 1 and 3 both hit: slot 1 is reported.
        setSlot(1, 1'b1, T_BIG, 10'd60);
        setSlot(2, 1'b0, T_NONE, 10'd0);
        setSlot(3, 1'b1, T_SMALL, 10'd50);
        applyStimulus("two_hits", 1'b1, 2'd1);
        checkOutput(5);

        // Inputs changing after the snapshot are ignored.
        clearOutputs();
        setSlot(3, 1'b0, T_NONE, 10'd0);
        applyStimulus("snapshot_only", 1'b1, 2'd1);
        repeat (2) @(negedge game_clk);
        setSlot(1, 1'b0, T_NONE, 10'd0);
        setDino(10'd0, 1'b0);
        checkOutput(3);

        // Leaving START during CHK2 abandons the scan.
        clearOutputs();
        setSlot(1, 1'b1, T_BIG, 10'd60);
        setDino(10'd400, 1'b1);
        @(negedge game_clk);
        game_state = GS_START;
        repeat (2) @(negedge game_clk);
        game_state = GS_END;
        pulses = 0;
        repeat (6) begin
            @(negedge game_clk);
            if (scan_done === 1'b1) pulses++;
        end
        checkValue("abort/scan_done_pulses", 16'(pulses), 16'd0);
        checkValue("abort/isColision", 16'(isColision), 16'd0);
        checkValue("abort/hit_slot", 16'(hit_slot), 16'd0);

        // Clear on the REPORT edge wins over the report.
        @(negedge game_clk);
        game_state = GS_START;
        repeat (4) @(negedge game_clk);
        game_state = GS_INIT;
        @(negedge game_clk);
        game_state = GS_END;
        checkValue("clear_vs_report/isColision", 16'(isColision), 16'd0);
        checkValue("clear_vs_report/scan_done", 16'(scan_done), 16'd0);

        // Async reset during CHK3 with a pending hit and a prior collision.
        applyStimulus("pre_reset_hit", 1'b1, 2'd1);
        checkOutput(5);
        @(negedge game_clk);
        game_state = GS_START;
        repeat (3) @(negedge game_clk);
        rst = 1'b1;
        #1;
        checkValue("async_rst/isColision", 16'(isColision), 16'd0);
        checkValue("async_rst/hit_slot", 16'(hit_slot), 16'd0);
        pulses = 0;
        repeat (3) begin
            @(negedge game_clk);
            if (scan_done === 1'b1) pulses++;
        end
        checkValue("async_rst/held_pulses", 16'(pulses), 16'd0);
        checkValue("async_rst/held_isColision", 16'(isColision), 16'd0);
        rst = 1'b0;
        sb.push_back('{tag: "post_reset_scan", coll: 1'b1, slot: 2'd1});
        checkOutput(5);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
